// File: rtl/wb_regfile.sv
// ============================================================================
// Module   : wb_regfile
// Brief    : Write-back stage and two-read/two-write architectural register
//            file. Optional write-through read bypass under WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_regfile #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Rdst1_in,
    input  logic [DATA_W-1:0] Rdst1_val_in,
    input  logic [DATA_W-1:0] Data_in,
    input  logic              memToReg_in,
    input  logic              reglow_write_in,
    input  logic [ADDR_W-1:0] Rdst2_in,
    input  logic [DATA_W-1:0] Rdst2_val_in,
    input  logic              reghigh_write_in,
    input  logic [ADDR_W-1:0] Rsrc1_in,
    input  logic [ADDR_W-1:0] Rsrc2_in,
    output logic [DATA_W-1:0] Rsrc1_val_out,
    output logic [DATA_W-1:0] Rsrc2_val_out,
    output logic [DATA_W-1:0] wb_val_out
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] w_wb1;
    logic [DATA_W-1:0] w_arr1;
    logic [DATA_W-1:0] w_arr2;

    assign w_wb1      = memToReg_in ? Data_in : Rdst1_val_in;
    assign wb_val_out = w_wb1;

    // Secondary write first so a colliding primary write overrides it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (reghigh_write_in) begin
                r_regs[Rdst2_in] <= Rdst2_val_in;
            end
            if (reglow_write_in) begin
                r_regs[Rdst1_in] <= w_wb1;
            end
        end
    end

    assign w_arr1 = r_regs[Rsrc1_in];
    assign w_arr2 = r_regs[Rsrc2_in];

`ifdef WB_BYPASS_EN
    // Pending writes are forwarded with the same priority as the collision rule.
    always_comb begin
        Rsrc1_val_out = w_arr1;
        Rsrc2_val_out = w_arr2;
        if (!reset) begin
            if (reglow_write_in && (Rdst1_in == Rsrc1_in)) begin
                Rsrc1_val_out = w_wb1;
            end else if (reghigh_write_in && (Rdst2_in == Rsrc1_in)) begin
                Rsrc1_val_out = Rdst2_val_in;
            end
            if (reglow_write_in && (Rdst1_in == Rsrc2_in)) begin
                Rsrc2_val_out = w_wb1;
            end else if (reghigh_write_in && (Rdst2_in == Rsrc2_in)) begin
                Rsrc2_val_out = Rdst2_val_in;
            end
        end
    end
`else
    assign Rsrc1_val_out = w_arr1;
    assign Rsrc2_val_out = w_arr2;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// Module   : tb_wb_regfile
// Brief    : Directed self-checking bench for wb_regfile.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic [2:0]  Rdst1_in;
    logic [15:0] Rdst1_val_in;
    logic [15:0] Data_in;
    logic        memToReg_in;
    logic        reglow_write_in;
    logic [2:0]  Rdst2_in;
    logic [15:0] Rdst2_val_in;
    logic        reghigh_write_in;
    logic [2:0]  Rsrc1_in;
    logic [2:0]  Rsrc2_in;
    logic [15:0] Rsrc1_val_out;
    logic [15:0] Rsrc2_val_out;
    logic [15:0] wb_val_out;

    int vectors;
    int miscompares;

    wb_regfile dut (
        .clk              (clk),
        .reset            (reset),
        .Rdst1_in         (Rdst1_in),
        .Rdst1_val_in     (Rdst1_val_in),
        .Data_in          (Data_in),
        .memToReg_in      (memToReg_in),
        .reglow_write_in  (reglow_write_in),
        .Rdst2_in         (Rdst2_in),
        .Rdst2_val_in     (Rdst2_val_in),
        .reghigh_write_in (reghigh_write_in),
        .Rsrc1_in         (Rsrc1_in),
        .Rsrc2_in         (Rsrc2_in),
        .Rsrc1_val_out    (Rsrc1_val_out),
        .Rsrc2_val_out    (Rsrc2_val_out),
        .wb_val_out       (wb_val_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reglow_write_in  = 1'b0;
        reghigh_write_in = 1'b0;
        memToReg_in      = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        Rdst1_in = '0; Rdst1_val_in = '0; Data_in = '0; memToReg_in = 1'b0;
        reglow_write_in = 1'b0; Rdst2_in = '0; Rdst2_val_in = '0;
        reghigh_write_in = 1'b0; Rsrc1_in = '0; Rsrc2_in = '0;
        tick();
        reset = 1'b0;

        // Reset state: every register reads zero on both ports
        for (int i = 0; i < 8; i++) begin
            Rsrc1_in = 3'(i);
            Rsrc2_in = 3'(7 - i);
            #1;
            check($sformatf("reset_rd1_r%0d", i), Rsrc1_val_out, 16'h0000);
            check($sformatf("reset_rd2_r%0d", 7 - i), Rsrc2_val_out, 16'h0000);
        end

        // wb_val_out follows inputs with enables off
        Rdst1_val_in = 16'hCAFE; Data_in = 16'h4321; memToReg_in = 1'b0;
        #1 check("wbval_alu", wb_val_out, 16'hCAFE);
        memToReg_in = 1'b1;
        #1 check("wbval_load", wb_val_out, 16'h4321);
        tick();
        Rsrc1_in = 3'd0;
        #1 check("no_enable_hold_r0", Rsrc1_val_out, 16'h0000);

        // Single ALU write
        Rdst1_in = 3'd3; Rdst1_val_in = 16'h1234; memToReg_in = 1'b0;
        reglow_write_in = 1'b1; Rsrc1_in = 3'd3;
        #1 check("alu_wbval_pre", wb_val_out, 16'h1234);
`ifdef WB_BYPASS_EN
        check("alu_rd_pre_edge", Rsrc1_val_out, 16'h1234);
`else
        check("alu_rd_pre_edge", Rsrc1_val_out, 16'h0000);
`endif
        tick();
        idle();
        #1 check("alu_write_r3", Rsrc1_val_out, 16'h1234);

        // Load plus dual write
        Rdst1_in = 3'd1; Data_in = 16'hBEEF; Rdst1_val_in = 16'h9999;
        memToReg_in = 1'b1; reglow_write_in = 1'b1;
        Rdst2_in = 3'd2; Rdst2_val_in = 16'h00FF; reghigh_write_in = 1'b1;
        tick();
        idle();
        Rsrc1_in = 3'd1; Rsrc2_in = 3'd2;
        #1 check("dual_r1_load", Rsrc1_val_out, 16'hBEEF);
        check("dual_r2_high", Rsrc2_val_out, 16'h00FF);

        // Collision: primary wins
        Rdst1_in = 3'd5; Rdst2_in = 3'd5; Rdst1_val_in = 16'hAAAA;
        Rdst2_val_in = 16'h5555; memToReg_in = 1'b0;
        reglow_write_in = 1'b1; reghigh_write_in = 1'b1; Rsrc1_in = 3'd5;
`ifdef WB_BYPASS_EN
        #1 check("collide_bypass", Rsrc1_val_out, 16'hAAAA);
`endif
        tick();
        idle();
        Rsrc2_in = 3'd3;
        #1 check("collide_r5", Rsrc1_val_out, 16'hAAAA);
        check("hold_r3", Rsrc2_val_out, 16'h1234);

        // Reset versus write
        Rdst1_in = 3'd4; Rdst1_val_in = 16'h0F0F; reglow_write_in = 1'b1;
        tick();
        idle();
        Rsrc1_in = 3'd4;
        #1 check("pre_reset_r4", Rsrc1_val_out, 16'h0F0F);
        reset = 1'b1; Rdst1_val_in = 16'h1111; reglow_write_in = 1'b1;
        #1 check("reset_suppresses_bypass", Rsrc1_val_out, 16'h0F0F);
        tick();
        reset = 1'b0;
        idle();
        Rsrc2_in = 3'd3;
        #1 check("reset_drop_r4", Rsrc1_val_out, 16'h0000);
        check("reset_clear_r3", Rsrc2_val_out, 16'h0000);

        // Bypass visibility before the edge
        Rdst1_in = 3'd6; Rdst1_val_in = 16'h0001; reglow_write_in = 1'b1;
        tick();
        Rdst1_val_in = 16'h7777; Rsrc2_in = 3'd6;
        Rdst2_in = 3'd7; Rdst2_val_in = 16'h2222; reghigh_write_in = 1'b1;
        Rsrc1_in = 3'd7;
`ifdef WB_BYPASS_EN
        #1 check("bypass_primary", Rsrc2_val_out, 16'h7777);
        check("bypass_secondary", Rsrc1_val_out, 16'h2222);
`else
        #1 check("bypass_primary", Rsrc2_val_out, 16'h0001);
        check("bypass_secondary", Rsrc1_val_out, 16'h0000);
`endif
        tick();
        idle();
        #1 check("post_edge_r6", Rsrc2_val_out, 16'h7777);
        check("post_edge_r7", Rsrc1_val_out, 16'h2222);

        // Register 0 is writable
        Rdst2_in = 3'd0; Rdst2_val_in = 16'hFFFF; reghigh_write_in = 1'b1;
        tick();
        idle();
        Rsrc1_in = 3'd0;
        #1 check("r0_writable", Rsrc1_val_out, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage and architectural register file; it is the consumer end of the MEM/WB pipeline buffer.
- Takes the buffer outputs (two destination indices, their values, load data, memToReg, high/low write enables) and commits up to two 16-bit register writes per cycle.
- Serves two combinational read ports to the decode stage.
- Exposes the selected write-back value for forwarding to the execute stage.

Parameters:
- DATA_W, 16, register and data width
- ADDR_W, 3, register index width
- NUM_REGS, 8, number of registers (2**ADDR_W)

Ports:
- clk  input  1  clock; register array updates on the rising edge
- reset  input  1  synchronous, active-high; clears the array
- Rdst1_in  input  3  primary destination index
- Rdst1_val_in  input  16  ALU result for the primary destination
- Data_in  input  16  memory load data
- memToReg_in  input  1  1 selects Data_in, 0 selects Rdst1_val_in, for the primary write
- reglow_write_in  input  1  primary write enable
- Rdst2_in  input  3  secondary destination index (high half or swap target)
- Rdst2_val_in  input  16  secondary write value
- reghigh_write_in  input  1  secondary write enable
- Rsrc1_in  input  3  read port 1 index
- Rsrc2_in  input  3  read port 2 index
- Rsrc1_val_out  output  16  read port 1 data
- Rsrc2_val_out  output  16  read port 2 data
- wb_val_out  output  16  selected primary write-back value, for forwarding

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Primary write value wb1 = memToReg_in ? Data_in : Rdst1_val_in. wb_val_out = wb1 combinationally at all times, independent of reglow_write_in.
- Rising edge of clk with reset=1: all NUM_REGS registers <= 0. Write enables are ignored that cycle.
- Rising edge with reset=0:
  - reglow_write_in=1: reg[Rdst1_in] <= wb1.
  - reghigh_write_in=1: reg[Rdst2_in] <= Rdst2_val_in.
- Both enables set, Rdst1_in == Rdst2_in: primary write wins. The register takes wb1; Rdst2_val_in is discarded.
- Both enables set, indices differ: both writes commit in the same edge.
- Neither enable set: array holds.
- Write latency: 1 edge. The value is visible in the stored array from the edge after the write.
- Timing: inputs come from a negedge-updated buffer, so they are stable for the half cycle before the rising edge. No input registering inside this block.
- Reads are combinational from the array (plus bypass, see Optional Feature). Read latency is 0.
- Reset mid-operation: a reset asserted in the same cycle as a write drops the write. After reset, every read returns 0 until the first write.
- Register 0 is an ordinary writable register, with no hardwired zero.
- Index width is exact (3 bits), so out-of-range indices cannot occur.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: each read port is write-through. If Rsrc_i_in matches an enabled write index in the current cycle, the port returns the pending value instead of the array value. Priority matches the write collision rule: a primary match (wb1) beats a secondary match (Rdst2_val_in), which beats the array. When reset=1, the bypass is suppressed and the port returns the array contents.
- Undefined: read ports return array contents only. A value written at edge N is readable only after edge N.

Test Plan:
- Reset: assert reset for 1 cycle, then read all 8 indices -> every read returns 16'h0000, and wb_val_out follows its inputs.
- Single ALU write: Rdst1=3, Rdst1_val=16'h1234, memToReg=0, reglow=1, one edge; Rsrc1=3 -> 16'h1234. wb_val_out = 16'h1234 before the edge.
- Load plus dual write: Rdst1=1, Data=16'hBEEF, memToReg=1, reglow=1; Rdst2=2, Rdst2_val=16'h00FF, reghigh=1; one edge -> reg1=16'hBEEF, reg2=16'h00FF.
- Collision: Rdst1=Rdst2=5, Rdst1_val=16'hAAAA, Rdst2_val=16'h5555, both enables set, memToReg=0 -> reg5=16'hAAAA.
- Reset versus write: reg4=16'h0F0F, then reset=1 with reglow=1, Rdst1=4, Rdst1_val=16'h1111 -> after the edge reg4=16'h0000.
- Bypass (macro defined): reg6=16'h0001, present Rdst1=6, Rdst1_val=16'h7777, reglow=1, Rsrc2=6 -> Rsrc2_val_out=16'h7777 before the edge. With the macro undefined, the same stimulus returns 16'h0001 until the edge.
